data_memory_ctrl: RTL

Parametrised single-port data memory with a valid/ready request interface, per-byte write enables, registered one-cycle read response and a self-clearing initialisation sweep after reset or on request. It sits between the processor's load/store stage and the data array and is the next-generation data memory. It generalises width and depth, adds bounds checking and guarantees a deterministic zeroed memory state.

---
 rtl/data_memory_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port data memory behind a valid/ready request
// port, with per-byte write enables, a one-cycle registered read response,
// out-of-range detection and a zeroing sweep after reset or on clr.
// Optional feature macro: DMEM_PARITY_EN (per-byte even parity plus a
// parity_inject port for forcing parity errors on writes).
module data_memory_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
`ifdef DMEM_PARITY_EN
   input  logic                parity_inject,
`endif
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                init_busy
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]  DepthExt = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LastIdx  = IDX_W'(DEPTH - 1);

   typedef enum logic {INIT, IDLE} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  sweepCnt_q, sweepCnt_d;
   logic              rspValid_q;
   logic [DATA_W-1:0] rspRdata_q;
   logic              rspErr_q;
   logic              initBusy_q;

   logic [DATA_W-1:0] mem_q [DEPTH];
`ifdef DMEM_PARITY_EN
   logic [NB-1:0]     par_q [DEPTH];
   logic              parityErr;
`endif

   logic              accept;
   logic              inRange;
   logic [IDX_W-1:0]  memIdx;
   logic              sweepWe;
   logic              rdHitErr;

   // Request is blocked during the sweep and whenever clr wins in IDLE.
   assign req_ready = (state_q == IDLE) && !clr;
   assign accept    = req_valid && req_ready;
   assign inRange   = ({1'b0, req_addr} < DepthExt);
   assign memIdx    = req_addr[IDX_W-1:0];
   assign sweepWe   = (state_q == INIT);

   // Next-state logic: sweep counter walks the array, clr restarts it.
   always_comb begin
      state_d    = state_q;
      sweepCnt_d = sweepCnt_q;
      case (state_q)
         INIT: begin
            if (sweepCnt_q == LastIdx) begin
               state_d    = IDLE;
               sweepCnt_d = '0;
            end else begin
               sweepCnt_d = sweepCnt_q + 1'b1;
            end
         end
         IDLE: begin
            if (clr) begin
               state_d    = INIT;
               sweepCnt_d = '0;
            end
         end
         default: begin
            state_d    = INIT;
            sweepCnt_d = '0;
         end
      endcase
   end

`ifdef DMEM_PARITY_EN
   // Any byte whose stored parity disagrees with its data flags an error.
   always_comb begin
      parityErr = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if ((^mem_q[memIdx][8*i +: 8]) != par_q[memIdx][i]) begin
            parityErr = 1'b1;
         end
      end
   end
   assign rdHitErr = !inRange || parityErr;
`else
   assign rdHitErr = !inRange;
`endif

   // State, sweep counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= INIT;
         sweepCnt_q <= '0;
         rspValid_q <= 1'b0;
         rspRdata_q <= '0;
         rspErr_q   <= 1'b0;
         initBusy_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         sweepCnt_q <= sweepCnt_d;
         initBusy_q <= (state_d == INIT);
         rspValid_q <= accept && !req_we;
         rspRdata_q <= (accept && !req_we && inRange) ? mem_q[memIdx] : '0;
         if (accept && req_we) begin
            rspErr_q <= !inRange;
         end else if (accept) begin
            rspErr_q <= rdHitErr;
         end else begin
            rspErr_q <= 1'b0;
         end
      end
   end

   // Storage array: the sweep zeroes one word per cycle, otherwise an
   // in-range accepted write updates only the enabled bytes.
   always_ff @(posedge clk) begin
      if (sweepWe) begin
         mem_q[sweepCnt_q] <= '0;
`ifdef DMEM_PARITY_EN
         par_q[sweepCnt_q] <= '0;
`endif
      end else if (accept && req_we && inRange) begin
         for (int i = 0; i < NB; i++) begin
            if (req_be[i]) begin
               mem_q[memIdx][8*i +: 8] <= req_wdata[8*i +: 8];
`ifdef DMEM_PARITY_EN
               par_q[memIdx][i] <= (^req_wdata[8*i +: 8]) ^ parity_inject;
`endif
            end
         end
      end
   end

   assign rsp_valid = rspValid_q;
   assign rsp_rdata = rspRdata_q;
   assign rsp_err   = rspErr_q;
   assign init_busy = initBusy_q;

endmodule
